// File: rtl/decode_stage_if.sv
// Handshake/bus bundle for the RV32I decode stage.
//   master : upstream fetch and downstream execute; drives if_valid/if_instruction/if_pc
//            and id_ready, and observes everything the decode stage produces.
//   slave  : the decode stage itself; accepts the fetch word and presents the decoded
//            instruction (id_*) together with if_ready.
interface decode_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 19
);
  logic              if_valid;
  logic              if_ready;
  logic [XLEN-1:0]   if_instruction;
  logic [XLEN-1:0]   if_pc;
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_rd_write;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_rs1_read;
  logic [REG_AW-1:0] id_rs1_addr;
  logic              id_rs2_read;
  logic [REG_AW-1:0] id_rs2_addr;
  logic [XLEN-1:0]   id_immediate;
  logic              id_illegal;

  modport master (
    output if_valid, if_instruction, if_pc, id_ready,
    input  if_ready, id_valid, id_pc, id_ctrl, id_rd_write, id_rd_addr,
           id_rs1_read, id_rs1_addr, id_rs2_read, id_rs2_addr, id_immediate, id_illegal
  );

  modport slave (
    input  if_valid, if_instruction, if_pc, id_ready,
    output if_ready, id_valid, id_pc, id_ctrl, id_rd_write, id_rd_addr,
           id_rs1_read, id_rs1_addr, id_rs2_read, id_rs2_addr, id_immediate, id_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I instruction-decode stage between fetch and execute.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   flush     : drops the held instructions and any word offered in the same cycle
//   bus       : decode_stage_if.slave -- if_* fetch handshake in, id_* decoded fields out
// id_ctrl layout (MSB..LSB, 19 bits):
//   alu_opcode[3:0] alu_src1_sel[1:0] alu_src2_sel[1:0] branch branch_opcode[2:0]
//   jump mem_read mem_write mem_opcode[2:0] unsign
//   alu_opcode: 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND
//   alu_src1_sel: 0 rs1 1 pc 2 zero ; alu_src2_sel: 0 rs2 1 immediate 2 constant 4
module decode_stage #(
  parameter int XLEN          = 32,
  parameter int REG_AW        = 5,
  parameter int ILLEGAL_CHECK = 1,
  parameter int SKID_EN       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  decode_stage_if.slave      bus
);
  localparam int CTRL_W = 19;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;
  localparam logic [1:0] SRC1_RS1 = 2'd0, SRC1_PC = 2'd1, SRC1_ZERO = 2'd2;
  localparam logic [1:0] SRC2_RS2 = 2'd0, SRC2_IMM = 2'd1, SRC2_FOUR = 2'd2;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic              rd_write;
    logic [REG_AW-1:0] rd_addr;
    logic              rs1_read;
    logic [REG_AW-1:0] rs1_addr;
    logic              rs2_read;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   immediate;
    logic              illegal;
  } dec_t;

  logic [XLEN-1:0] instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [3:0] alu_op;
  logic [1:0] src1_sel, src2_sel;
  logic       branch, jump, mem_read, mem_write, unsign;
  logic [2:0] branch_op, mem_op;
  logic       rd_we, rs1_re, rs2_re, opcode_ok, funct_ok, illegal;
  logic [XLEN-1:0] imm;
  dec_t       dec, out_q, skid_q;
  logic       id_valid_q, skid_valid;
  logic       in_xfer, out_free;

  assign instr  = bus.if_instruction;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{(XLEN-11){instr[31]}}, instr[30:20]};
  assign imm_s = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
  assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // funct3 -> ALU operation; alt selects SUB/SRA and is only meaningful for 000/101.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_f3 = ALU_SLL;
      3'b010:  alu_from_f3 = ALU_SLT;
      3'b011:  alu_from_f3 = ALU_SLTU;
      3'b100:  alu_from_f3 = ALU_XOR;
      3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

  // Combinational decode of the word currently offered by fetch.
  always_comb begin
    alu_op    = ALU_ADD;
    src1_sel  = SRC1_RS1;
    src2_sel  = SRC2_RS2;
    branch    = 1'b0;
    branch_op = 3'b000;
    jump      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_op    = 3'b000;
    unsign    = 1'b0;
    rd_we     = 1'b0;
    rs1_re    = 1'b0;
    rs2_re    = 1'b0;
    imm       = '0;
    opcode_ok = 1'b1;
    funct_ok  = 1'b1;
    case (opcode)
      OPC_LUI: begin
        src1_sel = SRC1_ZERO; src2_sel = SRC2_IMM; rd_we = 1'b1; imm = imm_u;
      end
      OPC_AUIPC: begin
        src1_sel = SRC1_PC; src2_sel = SRC2_IMM; rd_we = 1'b1; imm = imm_u;
      end
      // Jumps compute the link address pc+4 in the ALU; the target uses the immediate.
      OPC_JAL: begin
        src1_sel = SRC1_PC; src2_sel = SRC2_FOUR; rd_we = 1'b1; jump = 1'b1; imm = imm_j;
      end
      OPC_JALR: begin
        src1_sel = SRC1_PC; src2_sel = SRC2_FOUR; rd_we = 1'b1; jump = 1'b1;
        rs1_re = 1'b1; imm = imm_i; funct_ok = (funct3 == 3'b000);
      end
      // Equality compares subtract; signed/unsigned relations use SLT/SLTU.
      OPC_BRANCH: begin
        branch = 1'b1; branch_op = funct3; rs1_re = 1'b1; rs2_re = 1'b1; imm = imm_b;
        alu_op = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
        funct_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_LOAD: begin
        mem_read = 1'b1; mem_op = funct3; unsign = funct3[2]; rd_we = 1'b1;
        rs1_re = 1'b1; src2_sel = SRC2_IMM; imm = imm_i;
        funct_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OPC_STORE: begin
        mem_write = 1'b1; mem_op = funct3; rs1_re = 1'b1; rs2_re = 1'b1;
        src2_sel = SRC2_IMM; imm = imm_s; funct_ok = (funct3 <= 3'b010);
      end
      // ADDI has no subtract form, so the alternate bit is honoured only for shifts.
      OPC_OPIMM: begin
        rd_we = 1'b1; rs1_re = 1'b1; src2_sel = SRC2_IMM; imm = imm_i;
        alu_op = alu_from_f3(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        if (funct3 == 3'b001)
          funct_ok = (funct7 == 7'b0);
        else if (funct3 == 3'b101)
          funct_ok = (funct7 == 7'b0) || (funct7 == F7_ALT);
      end
      OPC_OP: begin
        rd_we = 1'b1; rs1_re = 1'b1; rs2_re = 1'b1;
        alu_op = alu_from_f3(funct3, funct7 == F7_ALT);
        funct_ok = (funct7 == 7'b0) ||
                   ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_MISC: begin
      end
      default: opcode_ok = 1'b0;
    endcase

    illegal = !opcode_ok || ((ILLEGAL_CHECK != 0) && !funct_ok);

    dec.pc        = bus.if_pc;
    dec.ctrl      = {alu_op, src1_sel, src2_sel, branch && !illegal, branch_op,
                     jump && !illegal, mem_read && !illegal, mem_write && !illegal,
                     mem_op, unsign};
    dec.rd_addr   = REG_AW'(instr[11:7]);
    dec.rs1_addr  = REG_AW'(instr[19:15]);
    dec.rs2_addr  = REG_AW'(instr[24:20]);
    dec.rd_write  = rd_we && !illegal && (instr[11:7] != 5'd0);
    dec.rs1_read  = rs1_re && (instr[19:15] != 5'd0);
    dec.rs2_read  = rs2_re && (instr[24:20] != 5'd0);
    dec.immediate = imm;
    dec.illegal   = illegal;
  end

  // With the skid buffer, if_ready comes straight from a register so fetch never sees
  // a combinational path from id_ready.
  assign bus.if_ready = (SKID_EN != 0) ? !skid_valid : (!id_valid_q || bus.id_ready);
  assign in_xfer      = bus.if_valid && bus.if_ready;
  assign out_free     = !id_valid_q || bus.id_ready;

  // Output register plus one skid entry. The skid only fills while the output is stalled,
  // and it always drains into the output before any new fetch word, preserving order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      id_valid_q <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        id_valid_q <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        out_q      <= dec;
        id_valid_q <= 1'b1;
      end else begin
        id_valid_q <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign bus.id_valid     = id_valid_q;
  assign bus.id_pc        = out_q.pc;
  assign bus.id_ctrl      = out_q.ctrl;
  assign bus.id_rd_write  = out_q.rd_write;
  assign bus.id_rd_addr   = out_q.rd_addr;
  assign bus.id_rs1_read  = out_q.rs1_read;
  assign bus.id_rs1_addr  = out_q.rs1_addr;
  assign bus.id_rs2_read  = out_q.rs2_read;
  assign bus.id_rs2_addr  = out_q.rs2_addr;
  assign bus.id_immediate = out_q.immediate;
  assign bus.id_illegal   = out_q.illegal;
endmodule
